// File: rtl/adc_sample_fifo_if.sv
// Bus between the ADC sample source / SDRAM write master and the sample FIFO.
interface adc_sample_fifo_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 7
);
  logic                  buffer_init;
  logic                  buffer_write;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  buffer_read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  buffer_empty;
  logic                  buffer_full;
  logic                  buffer_almost_full;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  underflow;
  logic [15:0]           drop_count;

  modport master (
    output buffer_init, buffer_write, adc_data, buffer_read,
    input  data_out, buffer_empty, buffer_full, buffer_almost_full,
           level, overflow, underflow, drop_count
  );

  modport slave (
    input  buffer_init, buffer_write, adc_data, buffer_read,
    output data_out, buffer_empty, buffer_full, buffer_almost_full,
           level, overflow, underflow, drop_count
  );
endinterface

// File: rtl/adc_sample_fifo.sv
// First-word-fall-through capture FIFO between the ADC sample bus and the
// SDRAM write master, with fill-level, sticky error and drop-count status.
module adc_sample_fifo #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned DEPTH_LOG2        = 7,
  parameter int unsigned ALMOST_FULL_LEVEL = 120
) (
  input  logic             clk,
  input  logic             reset_n,
  adc_sample_fifo_if.slave bus
);
  localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LVL   = (DEPTH_LOG2 + 1)'(ALMOST_FULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [15:0]           drop_count_q, drop_count_d;

  logic clear;
  logic empty, full;
  logic wr_ok, rd_ok;

  assign clear = !reset_n || bus.buffer_init;
  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);
  assign wr_ok = bus.buffer_write && (!full || bus.buffer_read);
  assign rd_ok = bus.buffer_read && !empty;

  // Next-state for pointers, level and sticky status.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    drop_count_d = drop_count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (bus.buffer_write && full && !bus.buffer_read) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
    end
    if (bus.buffer_read && empty) underflow_d = 1'b1;
  end

  // Control registers; reset and buffer_init both clear and override strobes.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Sample storage; contents survive reset/init, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (!clear && wr_ok) mem_q[wr_ptr_q] <= bus.adc_data;
  end

  assign bus.data_out           = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.buffer_empty       = empty;
  assign bus.buffer_full        = full;
  assign bus.buffer_almost_full = (level_q >= AF_LVL);
  assign bus.level              = level_q;
  assign bus.overflow           = overflow_q;
  assign bus.underflow          = underflow_q;
  assign bus.drop_count         = drop_count_q;
endmodule

// File: tb/tb_adc_sample_fifo.sv
// Bench for adc_sample_fifo: queue-based reference model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_adc_sample_fifo;
  logic clk = 1'b0;
  logic reset_n;

  adc_sample_fifo_if #(.DATA_WIDTH(16), .DEPTH_LOG2(7)) bus ();

  adc_sample_fifo #(
    .DATA_WIDTH(16),
    .DEPTH_LOG2(7),
    .ALMOST_FULL_LEVEL(120)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          chk_en      = 1'b0;

  // Reference model: the stored words in order plus sticky status.
  logic [15:0] mq[$];
  bit          m_ovf, m_unf;
  int unsigned m_drops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit init, input bit wr,
                            input logic [15:0] d, input bit rd);
    int unsigned n;
    n = mq.size();
    if (!rst || init) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_drops = 0;
    end else begin
      if (rd && n > 0) void'(mq.pop_front());
      if (wr && (n < 128 || rd)) mq.push_back(d);
      if (wr && n == 128 && !rd) begin
        m_ovf = 1;
        if (m_drops < 16'hFFFF) m_drops++;
      end
      if (rd && n == 0) m_unf = 1;
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, settle 1 time unit.
  task automatic cycle(input bit rst, input bit init, input bit wr,
                       input logic [15:0] d, input bit rd);
    reset_n          = rst;
    bus.buffer_init  = init;
    bus.buffer_write = wr;
    bus.adc_data     = d;
    bus.buffer_read  = rd;
    @(posedge clk);
    model_step(rst, init, wr, d, rd);
    #1;
    reset_n          = 1'b1;
    bus.buffer_init  = 1'b0;
    bus.buffer_write = 1'b0;
    bus.buffer_read  = 1'b0;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data_out", 32'(bus.data_out), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk("m_empty",    32'(bus.buffer_empty), 32'(mq.size() == 0));
      chk("m_full",     32'(bus.buffer_full), 32'(mq.size() == 128));
      chk("m_afull",    32'(bus.buffer_almost_full), 32'(mq.size() >= 120));
      chk("m_level",    32'(bus.level), 32'(mq.size()));
      chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("m_underflow",32'(bus.underflow), 32'(m_unf));
      chk("m_drops",    32'(bus.drop_count), m_drops);
    end
  end

  initial begin
    int unsigned w, p;
    reset_n = 1'b0;
    bus.buffer_init = 0; bus.buffer_write = 0; bus.buffer_read = 0; bus.adc_data = '0;
    cycle(0, 0, 0, 16'h0, 0);
    chk_en = 1'b1;
    cycle(0, 0, 0, 16'h0, 0);
    chk("rst_empty", 32'(bus.buffer_empty), 32'd1);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_data",  32'(bus.data_out), 32'd0);

    // 1: five writes, five pops
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 1, 16'(i), 0);
      if (i == 1) begin
        chk("t1_empty_drop", 32'(bus.buffer_empty), 32'd0);
        chk("t1_first_word", 32'(bus.data_out), 32'h0001);
      end
    end
    chk("t1_level5", 32'(bus.level), 32'd5);
    for (int i = 1; i <= 5; i++) begin
      chk("t1_pop_data", 32'(bus.data_out), 32'(i));
      cycle(1, 0, 0, 16'h0, 1);
    end
    chk("t1_empty", 32'(bus.buffer_empty), 32'd1);
    chk("t1_data0", 32'(bus.data_out), 32'd0);
    chk("t1_no_unf", 32'(bus.underflow), 32'd0);

    // 2: fill, overflow by 3, drain
    for (int i = 0; i < 128; i++) begin
      cycle(1, 0, 1, 16'h1000 + 16'(i), 0);
      chk("t2_afull", 32'(bus.buffer_almost_full), 32'(i + 1 >= 120));
    end
    chk("t2_full", 32'(bus.buffer_full), 32'd1);
    chk("t2_level", 32'(bus.level), 32'd128);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 16'hDEAD, 0);
    chk("t2_ovf", 32'(bus.overflow), 32'd1);
    chk("t2_drops", 32'(bus.drop_count), 32'd3);
    chk("t2_level_hold", 32'(bus.level), 32'd128);
    for (int i = 0; i < 128; i++) begin
      chk("t2_pop_data", 32'(bus.data_out), 32'h1000 + 32'(i));
      cycle(1, 0, 0, 16'h0, 1);
    end
    chk("t2_empty", 32'(bus.buffer_empty), 32'd1);

    // 3: write+read while full
    cycle(1, 1, 0, 16'h0, 0);
    for (int i = 0; i < 128; i++) cycle(1, 0, 1, 16'h1000 + 16'(i), 0);
    chk("t3_before", 32'(bus.data_out), 32'h1000);
    cycle(1, 0, 1, 16'hAAAA, 1);
    chk("t3_after", 32'(bus.data_out), 32'h1001);
    chk("t3_level", 32'(bus.level), 32'd128);
    chk("t3_no_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 128; i++) begin
      chk("t3_pop_data", 32'(bus.data_out), (i < 127) ? 32'h1001 + 32'(i) : 32'hAAAA);
      cycle(1, 0, 0, 16'h0, 1);
    end

    // 4: write+read while empty
    cycle(1, 0, 1, 16'h1234, 1);
    chk("t4_level", 32'(bus.level), 32'd1);
    chk("t4_unf", 32'(bus.underflow), 32'd1);
    chk("t4_data", 32'(bus.data_out), 32'h1234);
    cycle(1, 1, 0, 16'h0, 0);

    // 5: streaming with wrap
    w = 0; p = 0;
    while (w < 300) begin
      bit rd;
      rd = (mq.size() >= 2 && (w % 3) != 0) || mq.size() >= 8;
      if (rd) begin
        chk("t5_stream", 32'(bus.data_out), 32'h2000 + p);
        p++;
      end
      cycle(1, 0, 1, 16'h2000 + 16'(w), rd);
      w++;
      if (bus.level > 10 || bus.level < 1) chk("t5_level_range", 32'(bus.level), 32'd10);
    end
    while (mq.size() > 0) begin
      chk("t5_drain", 32'(bus.data_out), 32'h2000 + p);
      p++;
      cycle(1, 0, 0, 16'h0, 1);
    end
    chk("t5_count", p, 32'd300);
    chk("t5_no_ovf", 32'(bus.overflow), 32'd0);
    chk("t5_no_unf", 32'(bus.underflow), 32'd0);

    // 6: init, then reset, with strobes asserted, from level 50 + overflow
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 129; i++) cycle(1, 0, 1, 16'h3000 + 16'(i), 0);
      for (int i = 0; i < 78; i++) cycle(1, 0, 0, 16'h0, 1);
      chk("t6_pre_level", 32'(bus.level), 32'd50);
      chk("t6_pre_ovf", 32'(bus.overflow), 32'd1);
      if (k == 0) cycle(1, 1, 1, 16'h5555, 1);
      else        cycle(0, 0, 1, 16'h5555, 1);
      chk("t6_level", 32'(bus.level), 32'd0);
      chk("t6_empty", 32'(bus.buffer_empty), 32'd1);
      chk("t6_ovf", 32'(bus.overflow), 32'd0);
      chk("t6_drops", 32'(bus.drop_count), 32'd0);
      chk("t6_data", 32'(bus.data_out), 32'd0);
    end

    cycle(1, 0, 0, 16'h0, 0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
